// File: rtl/mxv_frame_parser_pkg.sv
// ---------------------------------------------------------------------------
// mxv_frame_parser_pkg
// Shared definitions for the matrix/vector frame parser:
//   - frame delimiters and command codes
//   - error-code enum reported on err_code
//   - parser FSM state enum and decoded-command enum
// ---------------------------------------------------------------------------
package mxv_frame_parser_pkg;

    // Frame delimiters
    localparam logic [7:0] FRAME_SOF = 8'hFE;
    localparam logic [7:0] FRAME_EOF = 8'hEF;

    // Command codes
    localparam logic [7:0] CMD_SIZE   = 8'h01;
    localparam logic [7:0] CMD_REPEAT = 8'h02;
    localparam logic [7:0] CMD_START  = 8'h03;
    localparam logic [7:0] CMD_MV     = 8'h04;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_CMD     = 3'd1,  // unknown command byte
        ERR_LEN     = 3'd2,  // LEN does not match command / current N
        ERR_SIZE    = 3'd3,  // SIZE payload outside 1..NMAX
        ERR_EOF     = 3'd4,  // terminator byte is not 0xEF
        ERR_TIMEOUT = 3'd5   // inter-byte gap too long inside a frame
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_LEN,
        ST_GET_CMD,
        ST_PAYLOAD,
        ST_GET_EF
    } state_e;

    typedef enum logic [1:0] {
        OP_SIZE,
        OP_REPEAT,
        OP_START,
        OP_MV
    } op_e;

endpackage

// File: rtl/mxv_idle_timer.sv
// ---------------------------------------------------------------------------
// mxv_idle_timer
// Down-counter measuring idle cycles inside a frame.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   load_i   : reload the count to TIMEOUT and arm the timer
//   clear_i  : disarm the timer (has priority over load_i)
//   expire_o : high during the TIMEOUT-th consecutive cycle without a load
// TIMEOUT = 0 leaves the timer permanently disarmed.
// ---------------------------------------------------------------------------
module mxv_idle_timer #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int   CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic ENABLED = (TIMEOUT != 0);

    logic [CW-1:0] cnt_q;
    logic          armed_q;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values and simulation matches the synthesized hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else if (clear_i) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else if (load_i) begin
            cnt_q   <= CW'(TIMEOUT);
            armed_q <= ENABLED;
        end else if (armed_q && (cnt_q != '0)) begin
            cnt_q   <= cnt_q - CW'(1);
        end
    end

    // Count holds TIMEOUT during the first idle cycle, so it reads 1 during
    // the TIMEOUT-th one.
    assign expire_o = armed_q && (cnt_q == CW'(1));

endmodule

// File: rtl/mxv_frame_parser.sv
// ---------------------------------------------------------------------------
// mxv_frame_parser
// Parses byte frames  0xFE, LEN, CMD, payload, 0xEF  and drives matrix /
// vector element writes and command pulses. All outputs are registered, so
// every response appears the cycle after the byte that caused it.
//   clk, rst            : clock and synchronous active-high reset
//   rx_data, rx_valid   : received byte stream, one-cycle valid
//   n_size              : current matrix dimension N (0 until a SIZE frame)
//   start_p, repeat_p   : START / REPEAT frame accepted
//   m_we/m_row/m_col/m_data : matrix element write
//   v_we/v_idx/v_data   : vector element write
//   mv_done             : MV frame accepted
//   err_p, err_code     : error pulse and its code (code holds until next error)
// ---------------------------------------------------------------------------
module mxv_frame_parser
    import mxv_frame_parser_pkg::*;
#(
    parameter int NMAX    = 8,
    parameter int DWUART  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DWUART-1:0]          rx_data,
    input  logic                       rx_valid,
    output logic [$clog2(NMAX+1)-1:0]  n_size,
    output logic                       start_p,
    output logic                       repeat_p,
    output logic                       m_we,
    output logic [$clog2(NMAX)-1:0]    m_row,
    output logic [$clog2(NMAX)-1:0]    m_col,
    output logic [DWUART-1:0]          m_data,
    output logic                       v_we,
    output logic [$clog2(NMAX)-1:0]    v_idx,
    output logic [DWUART-1:0]          v_data,
    output logic                       mv_done,
    output logic                       err_p,
    output logic [2:0]                 err_code
);

    localparam int NW = $clog2(NMAX + 1);
    localparam int IW = $clog2(NMAX);

    localparam logic [DWUART-1:0] SOF_B    = DWUART'(FRAME_SOF);
    localparam logic [DWUART-1:0] EOF_B    = DWUART'(FRAME_EOF);
    localparam logic [DWUART-1:0] SIZE_B   = DWUART'(CMD_SIZE);
    localparam logic [DWUART-1:0] REPEAT_B = DWUART'(CMD_REPEAT);
    localparam logic [DWUART-1:0] START_B  = DWUART'(CMD_START);
    localparam logic [DWUART-1:0] MV_B     = DWUART'(CMD_MV);

    // Frame-tracking state
    state_e            state_q,     state_d;
    op_e               op_q,        op_d;
    logic [DWUART-1:0] len_q,       len_d;
    logic [DWUART-1:0] pay_cnt_q,   pay_cnt_d;
    logic [NW-1:0]     size_pend_q, size_pend_d;
    logic [IW-1:0]     row_q,       row_d;
    logic [IW-1:0]     col_q,       col_d;
    logic              vec_q,       vec_d;

    // Output registers
    logic [NW-1:0]     n_size_q,    n_size_d;
    logic              start_q,     start_d;
    logic              repeat_q,    repeat_d;
    logic              mv_done_q,   mv_done_d;
    logic              m_we_q,      m_we_d;
    logic [IW-1:0]     m_row_q,     m_row_d;
    logic [IW-1:0]     m_col_q,     m_col_d;
    logic [DWUART-1:0] m_data_q,    m_data_d;
    logic              v_we_q,      v_we_d;
    logic [IW-1:0]     v_idx_q,     v_idx_d;
    logic [DWUART-1:0] v_data_q,    v_data_d;
    logic              err_p_q,     err_p_d;
    err_code_e         err_code_q,  err_code_d;

    // Command decode of the byte currently on rx_data
    logic              cmd_known;
    op_e               cmd_op;
    logic [DWUART-1:0] cmd_len;
    logic [DWUART-1:0] cmd_pay;
    logic [DWUART-1:0] mv_pay;
    logic              len_bad;
    logic              size_bad;
    logic [IW-1:0]     n_last;
    logic              tmr_expire;

    assign mv_pay   = DWUART'(n_size_q) * DWUART'(n_size_q) + DWUART'(n_size_q);
    assign n_last   = IW'(n_size_q - NW'(1));
    assign size_bad = (rx_data == '0) || (rx_data > DWUART'(NMAX));

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cmd_known = 1'b1;
        cmd_op    = OP_REPEAT;
        cmd_len   = DWUART'(1);
        cmd_pay   = '0;
        if (rx_data == SIZE_B) begin
            cmd_op  = OP_SIZE;
            cmd_len = DWUART'(2);
            cmd_pay = DWUART'(1);
        end else if (rx_data == REPEAT_B) begin
            cmd_op  = OP_REPEAT;
        end else if (rx_data == START_B) begin
            cmd_op  = OP_START;
        end else if (rx_data == MV_B) begin
            cmd_op  = OP_MV;
            cmd_len = mv_pay + DWUART'(1);
            cmd_pay = mv_pay;
        end else begin
            cmd_known = 1'b0;
        end
    end

    // An MV with N=0 has no meaningful payload, so it is rejected as a
    // length error even though LEN=1 would otherwise match.
    assign len_bad = (len_q != cmd_len) || ((cmd_op == OP_MV) && (n_size_q == '0));

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        len_d       = len_q;
        pay_cnt_d   = pay_cnt_q;
        size_pend_d = size_pend_q;
        row_d       = row_q;
        col_d       = col_q;
        vec_d       = vec_q;
        n_size_d    = n_size_q;
        start_d     = 1'b0;
        repeat_d    = 1'b0;
        mv_done_d   = 1'b0;
        m_we_d      = 1'b0;
        m_row_d     = m_row_q;
        m_col_d     = m_col_q;
        m_data_d    = m_data_q;
        v_we_d      = 1'b0;
        v_idx_d     = v_idx_q;
        v_data_d    = v_data_q;
        err_p_d     = 1'b0;
        err_code_d  = err_code_q;

        if ((state_q != ST_IDLE) && !rx_valid && tmr_expire) begin
            err_p_d    = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = ST_IDLE;
        end else if (rx_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    // A start byte landing while err_p is high belongs to the
                    // failed frame's tail and is dropped.
                    if ((rx_data == SOF_B) && !err_p_q) begin
                        state_d = ST_GET_LEN;
                    end
                end
                ST_GET_LEN: begin
                    len_d   = rx_data;
                    state_d = ST_GET_CMD;
                end
                ST_GET_CMD: begin
                    if (!cmd_known) begin
                        err_p_d    = 1'b1;
                        err_code_d = ERR_CMD;
                        state_d    = ST_IDLE;
                    end else if (len_bad) begin
                        err_p_d    = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = ST_IDLE;
                    end else begin
                        op_d      = cmd_op;
                        pay_cnt_d = cmd_pay;
                        row_d     = '0;
                        col_d     = '0;
                        vec_d     = 1'b0;
                        state_d   = (cmd_pay == '0) ? ST_GET_EF : ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    // Payload bytes are counted, never compared against the
                    // delimiters, so 0xFE / 0xEF pass through as data.
                    pay_cnt_d = pay_cnt_q - DWUART'(1);
                    if (pay_cnt_q == DWUART'(1)) begin
                        state_d = ST_GET_EF;
                    end
                    if (op_q == OP_SIZE) begin
                        if (size_bad) begin
                            err_p_d    = 1'b1;
                            err_code_d = ERR_SIZE;
                            state_d    = ST_IDLE;
                        end else begin
                            size_pend_d = rx_data[NW-1:0];
                        end
                    end else if (op_q == OP_MV) begin
                        if (!vec_q) begin
                            m_we_d   = 1'b1;
                            m_row_d  = row_q;
                            m_col_d  = col_q;
                            m_data_d = rx_data;
                            if (col_q == n_last) begin
                                col_d = '0;
                                if (row_q == n_last) begin
                                    row_d = '0;
                                    vec_d = 1'b1;
                                end else begin
                                    row_d = row_q + IW'(1);
                                end
                            end else begin
                                col_d = col_q + IW'(1);
                            end
                        end else begin
                            v_we_d   = 1'b1;
                            v_idx_d  = col_q;
                            v_data_d = rx_data;
                            col_d    = col_q + IW'(1);
                        end
                    end
                end
                ST_GET_EF: begin
                    state_d = ST_IDLE;
                    if (rx_data == EOF_B) begin
                        unique case (op_q)
                            OP_SIZE:   n_size_d  = size_pend_q;
                            OP_REPEAT: repeat_d  = 1'b1;
                            OP_START:  start_d   = 1'b1;
                            OP_MV:     mv_done_d = 1'b1;
                            default:   ;
                        endcase
                    end else begin
                        err_p_d    = 1'b1;
                        err_code_d = ERR_EOF;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Every accepted byte restarts the idle count; returning to IDLE stops it.
    mxv_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (rx_valid),
        .clear_i  (state_d == ST_IDLE),
        .expire_o (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_SIZE;
            len_q       <= '0;
            pay_cnt_q   <= '0;
            size_pend_q <= '0;
            row_q       <= '0;
            col_q       <= '0;
            vec_q       <= 1'b0;
            n_size_q    <= '0;
            start_q     <= 1'b0;
            repeat_q    <= 1'b0;
            mv_done_q   <= 1'b0;
            m_we_q      <= 1'b0;
            m_row_q     <= '0;
            m_col_q     <= '0;
            m_data_q    <= '0;
            v_we_q      <= 1'b0;
            v_idx_q     <= '0;
            v_data_q    <= '0;
            err_p_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            len_q       <= len_d;
            pay_cnt_q   <= pay_cnt_d;
            size_pend_q <= size_pend_d;
            row_q       <= row_d;
            col_q       <= col_d;
            vec_q       <= vec_d;
            n_size_q    <= n_size_d;
            start_q     <= start_d;
            repeat_q    <= repeat_d;
            mv_done_q   <= mv_done_d;
            m_we_q      <= m_we_d;
            m_row_q     <= m_row_d;
            m_col_q     <= m_col_d;
            m_data_q    <= m_data_d;
            v_we_q      <= v_we_d;
            v_idx_q     <= v_idx_d;
            v_data_q    <= v_data_d;
            err_p_q     <= err_p_d;
            err_code_q  <= err_code_d;
        end
    end

    assign n_size   = n_size_q;
    assign start_p  = start_q;
    assign repeat_p = repeat_q;
    assign mv_done  = mv_done_q;
    assign m_we     = m_we_q;
    assign m_row    = m_row_q;
    assign m_col    = m_col_q;
    assign m_data   = m_data_q;
    assign v_we     = v_we_q;
    assign v_idx    = v_idx_q;
    assign v_data   = v_data_q;
    assign err_p    = err_p_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_mxv_frame_parser.sv
// ---------------------------------------------------------------------------
// tb_mxv_frame_parser
// Directed frames are sent byte by byte; the expected DUT events are queued
// before each frame and a negedge monitor pops and compares every strobe,
// pulse and n_size change the DUT presents.
// ---------------------------------------------------------------------------
module tb_mxv_frame_parser;

    localparam int NMAX    = 8;
    localparam int DWUART  = 8;
    localparam int TIMEOUT = 1023;

    // Event kinds in the top byte of a packed event word {kind, a, b, data}
    localparam logic [7:0] K_MW     = 8'd1;
    localparam logic [7:0] K_VW     = 8'd2;
    localparam logic [7:0] K_START  = 8'd3;
    localparam logic [7:0] K_REPEAT = 8'd4;
    localparam logic [7:0] K_MVDONE = 8'd5;
    localparam logic [7:0] K_ERR    = 8'd6;
    localparam logic [7:0] K_NSIZE  = 8'd7;

    typedef struct {
        logic [31:0] word;
        longint      cyc;   // -1: arrival cycle not checked
    } ev_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [DWUART-1:0] rx_data;
    logic              rx_valid;
    logic [3:0]        n_size;
    logic              start_p;
    logic              repeat_p;
    logic              m_we;
    logic [2:0]        m_row;
    logic [2:0]        m_col;
    logic [7:0]        m_data;
    logic              v_we;
    logic [2:0]        v_idx;
    logic [7:0]        v_data;
    logic              mv_done;
    logic              err_p;
    logic [2:0]        err_code;

    ev_t         sb[$];
    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    longint      cyc    = 0;
    logic        mon_en = 1'b0;
    logic [3:0]  prev_n = '0;
    logic [63:0] outs;

    assign outs = {26'd0, n_size, start_p, repeat_p, m_we, m_row, m_col, m_data,
                   v_we, v_idx, v_data, mv_done, err_p, err_code};

    mxv_frame_parser #(
        .NMAX    (NMAX),
        .DWUART  (DWUART),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .n_size   (n_size),
        .start_p  (start_p),
        .repeat_p (repeat_p),
        .m_we     (m_we),
        .m_row    (m_row),
        .m_col    (m_col),
        .m_data   (m_data),
        .v_we     (v_we),
        .v_idx    (v_idx),
        .v_data   (v_data),
        .mv_done  (mv_done),
        .err_p    (err_p),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic exp_ev(input logic [7:0] k, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] d, input longint c);
        ev_t e;
        e.word = {k, a, b, d};
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        ev_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_event: got %h, expected none", got);
        end else begin
            e = sb.pop_front();
            check($sformatf("event_k%0d", e.word[31:24]), 64'(got), 64'(e.word));
            if (e.cyc >= 0) check("event_cycle", 64'(cyc), 64'(e.cyc));
        end
    endtask

    // Monitor: every DUT-presented event is matched against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (m_we)     sb_pop({K_MW, 5'd0, m_row, 5'd0, m_col, m_data});
            if (v_we)     sb_pop({K_VW, 5'd0, v_idx, 8'd0, v_data});
            if (start_p)  sb_pop({K_START, 24'd0});
            if (repeat_p) sb_pop({K_REPEAT, 24'd0});
            if (mv_done)  sb_pop({K_MVDONE, 24'd0});
            if (err_p)    sb_pop({K_ERR, 16'd0, 5'd0, err_code});
            if (n_size !== prev_n) sb_pop({K_NSIZE, 16'd0, 4'd0, n_size});
        end
        prev_n = n_size;
    end

    // Called at posedge+1; returns at posedge+1 of the edge that sampled b.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    // Sends the n low bytes of v, most significant first, with no gaps.
    task automatic send_frame(input int n, input logic [255:0] v);
        for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        longint k;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        check("reset_outputs", outs, 64'd0);
        mon_en = 1'b1;

        // SIZE 4: n_size updates on the EF edge
        exp_ev(K_NSIZE, 0, 0, 8'd4, -1);
        send_frame(5, 'hFE020104EF);
        check("size4_n_after_ef", 64'(n_size), 64'd4);
        idle(3);

        // SIZE 9 and SIZE 0 are out of range; n_size must not move
        exp_ev(K_ERR, 0, 0, 8'd3, -1);
        send_frame(5, 'hFE020109EF);
        idle(3);
        check("size9_n_unchanged", 64'(n_size), 64'd4);
        exp_ev(K_ERR, 0, 0, 8'd3, -1);
        send_frame(5, 'hFE020100EF);
        idle(3);

        // SIZE at the NMAX boundary is accepted
        exp_ev(K_NSIZE, 0, 0, 8'd8, -1);
        send_frame(5, 'hFE020108EF);
        idle(3);

        // N=3 MV: column wraps every 3, vector follows matrix
        exp_ev(K_NSIZE, 0, 0, 8'd3, -1);
        send_frame(5, 'hFE020103EF);
        idle(2);
        for (int i = 0; i < 12; i++) begin
            if (i < 9) exp_ev(K_MW, 8'(i / 3), 8'(i % 3), 8'(i + 1), -1);
            else       exp_ev(K_VW, 8'(i - 9), 8'd0, 8'(i + 1), -1);
        end
        exp_ev(K_MVDONE, 0, 0, 0, -1);
        send_frame(3, 'hFE0D04);
        for (int i = 0; i < 12; i++) send_byte(8'(i + 1));
        send_byte(8'hEF);
        idle(3);

        // N=2 MV reference frame
        exp_ev(K_NSIZE, 0, 0, 8'd2, -1);
        send_frame(5, 'hFE020102EF);
        exp_ev(K_MW, 0, 0, 8'h11, -1);
        exp_ev(K_MW, 0, 1, 8'h22, -1);
        exp_ev(K_MW, 1, 0, 8'h33, -1);
        exp_ev(K_MW, 1, 1, 8'h44, -1);
        exp_ev(K_VW, 0, 0, 8'h55, -1);
        exp_ev(K_VW, 1, 0, 8'h66, -1);
        exp_ev(K_MVDONE, 0, 0, 0, -1);
        send_frame(10, 'hFE07041122334455_66EF);
        idle(3);

        // Delimiter values inside the payload are plain data
        exp_ev(K_MW, 0, 0, 8'hFE, -1);
        exp_ev(K_MW, 0, 1, 8'hEF, -1);
        exp_ev(K_MW, 1, 0, 8'h01, -1);
        exp_ev(K_MW, 1, 1, 8'h02, -1);
        exp_ev(K_VW, 0, 0, 8'hEF, -1);
        exp_ev(K_VW, 1, 0, 8'hFE, -1);
        exp_ev(K_MVDONE, 0, 0, 0, -1);
        send_frame(10, 'hFE0704FEEF0102EFFEEF);
        idle(3);

        // MV LEN wrong for N=2
        exp_ev(K_ERR, 0, 0, 8'd2, -1);
        send_frame(3, 'hFE0604);
        idle(3);

        // Unknown CMD, then a START frame is still accepted
        exp_ev(K_ERR, 0, 0, 8'd1, -1);
        send_frame(3, 'hFE0109);
        idle(3);
        exp_ev(K_START, 0, 0, 0, -1);
        send_frame(4, 'hFE0103EF);
        idle(3);

        // 0xFE in the error cycle is discarded, so the START after it is lost
        exp_ev(K_ERR, 0, 0, 8'd1, -1);
        send_frame(7, 'hFE0109FE0103EF);
        idle(3);

        // Bad terminator: no start_p
        exp_ev(K_ERR, 0, 0, 8'd4, -1);
        send_frame(4, 'hFE0103AA);
        idle(3);

        // TIMEOUT-1 idle cycles are tolerated
        exp_ev(K_START, 0, 0, 0, -1);
        send_frame(2, 'hFE01);
        idle(TIMEOUT - 1);
        send_frame(2, 'h03EF);
        idle(3);

        // TIMEOUT idle cycles after LEN: error registered TIMEOUT edges later
        send_frame(2, 'hFE01);
        k = cyc;
        exp_ev(K_ERR, 0, 0, 8'd5, k + TIMEOUT);
        idle(TIMEOUT + 3);

        // Reset mid MV payload: writes already made stay, frame is dropped
        exp_ev(K_MW, 0, 0, 8'h11, -1);
        exp_ev(K_MW, 0, 1, 8'h22, -1);
        exp_ev(K_NSIZE, 0, 0, 8'd0, -1);
        send_frame(5, 'hFE07041122);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_mid_frame_outputs", outs, 64'd0);

        // Back-to-back REPEAT and START directly after reset
        exp_ev(K_REPEAT, 0, 0, 0, -1);
        exp_ev(K_START, 0, 0, 0, -1);
        send_frame(8, 'hFE0102EFFE0103EF);
        idle(3);

        // MV with n_size=0
        exp_ev(K_ERR, 0, 0, 8'd2, -1);
        send_frame(4, 'hFE0104EF);
        idle(5);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
